sc_mem_access_unit: RTL and testbench
=====================================

# sc_mem_access_unit

Load/store sequencer between the single-cycle CPU's memory stage and the word-only data memory, which reads combinationally and writes on posedge `clk`. It accepts byte, halfword and word requests. For loads it extracts and sign- or zero-extends the addressed lane. For sub-word stores it performs a read-modify-write, because the data memory has no byte enables. The CPU stalls on `busy` and resumes on the one-cycle `done` pulse.

## Interface
- `ADDR_W`, 32, byte-address width of the request and memory address buses.
- `clk`  in  1  system clock; all state changes on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  request strobe; sampled only in IDLE.
- `wr`  in  1  1 = store, 0 = load.
- `size`  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- `sign`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `addr`  in  ADDR_W  byte address.
- `wdata`  in  32  store data, right-aligned.
- `rdata`  out  32  load result, registered, held until the next load completes.
- `done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high when state is not IDLE.
- `err`  out  1  misalignment flag, pulses with `done`; tied 0 unless MEM_MISALIGN_TRAP_EN.
- `mem_addr`  out  ADDR_W  word-aligned address: {latched addr[ADDR_W-1:2], 2'b00}.
- `mem_wdata`  out  32  merged store word; 0 outside WR.
- `mem_we`  out  1  write enable, asserted only in WR.
- `mem_rdata`  in  32  combinational read data from the data memory.

## Operation
- FSM states: IDLE, RD, WR.
- IDLE, on `req`:
  - Latch `addr`, `size`, `wr`, `sign`, `wdata`.
  - Next state: load → RD; word store → WR; byte/half store → RD.
- RD:
  - Capture `mem_rdata`.
  - Load: write the extracted lane to `rdata`, set `done`, go to IDLE.
  - Sub-word store: write the merged word into the merge register, go to WR.
- WR: `mem_we`=1 and `mem_wdata`=merge register (or latched `wdata` for word stores); set `done`, go to IDLE.
- Lanes are little-endian:
  - Byte k = bits [8k+7:8k], with k = addr[1:0].
  - Halfword = bits [31:16] when addr[1]=1, else [15:0].
- Extension: when `sign`=1 the lane MSB fills the upper bits; otherwise the upper bits are 0.
- Merge: only the target lane is replaced with `wdata`[7:0] or `wdata`[15:0]; the other bytes are kept from the captured word.
- Without the trap, the ignored low address bits are: halfword uses addr[1] only; word ignores addr[1:0].
- `done` and `err` are registered and high for exactly one cycle.
- A `req` present in the `done` cycle is accepted, because the FSM is already in IDLE.
- `req` in RD/WR is ignored; there is no queue, so the CPU must hold it low while `busy`.

## Timing
- Reset values: state IDLE; `rdata`=0, `done`=0, `err`=0, `busy`=0, `mem_we`=0, `mem_wdata`=0.
- Latency from the accept edge (cycle 0) to `done` high:
  - Load: cycle 2.
  - Word store: cycle 2; the memory is written at the edge ending cycle 1.
  - Sub-word store: cycle 3; RD in cycle 1, WR in cycle 2.
- `mem_we` = (state==WR) & ~`rst`. A reset asserted during WR suppresses the write.
- `rst` mid-operation: the FSM returns to IDLE, no `done` is generated, and `rdata` clears to 0.
- `mem_addr` is stable from cycle 1 until IDLE.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - Misaligned means: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - A misaligned request is accepted and skips RD/WR: `done`=1 and `err`=1 in cycle 1.
  - `mem_we` is never asserted for it, and `rdata` is unchanged.
- `MEM_MISALIGN_TRAP_EN` undefined: `err` is constant 0 and the low bits are ignored as listed under Operation.

## Test plan
- Signed byte load: memory word 0x50 = 0x800000A3; load byte at 0x50 with `sign`=1 → `rdata`=0xFFFFFFA3 and `done` in cycle 2; `mem_we` never 1. Repeat with `sign`=0 → `rdata`=0x000000A3.
- Byte store: store byte 0x5A to 0x52 over 0x800000A3 → RD then WR; `mem_wdata`=0x805A00A3; `done` in cycle 3. Read back the word → 0x805A00A3.
- Word store then halfword load: store word 0x12345678 to 0x54 → single WR cycle, `done` in cycle 2. Then load halfword at 0x56 with `sign`=1 → `rdata`=0x00001234. Load halfword at 0x54 with `sign`=1 → 0x00005678.
- Reset during WR: store halfword 0xBEEF to 0x58 with `rst` high during the WR cycle → `mem_we`=0, memory unchanged, `done` never pulses, FSM in IDLE.
- Back-to-back: assert a new load `req` in the `done` cycle of a store → it is accepted immediately and completes 2 cycles later.
- Misaligned word load at 0x51:
  - With MEM_MISALIGN_TRAP_EN → `done`=1 and `err`=1 in cycle 1, `rdata` unchanged.
  - Without it → word at 0x50 is returned, `err`=0.

Source files
------------

// File: rtl/sc_mem_access_unit.sv
// Load/store sequencer between the CPU memory stage and a word-only data memory.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned requests complete at once with err).
module sc_mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_wr;
  logic              r_sign;
  logic [31:0]       r_wdata;
  logic [31:0]       r_merge;
  logic [31:0]       r_rdata;
  logic              r_done;
  logic              r_err;
  logic              w_misalign;

  function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] sz,
                                            input logic [1:0] lo, input logic sgn);
    logic signed [7:0]  v_b;
    logic signed [15:0] v_h;
    logic [31:0]        v_res;
    v_b = word[{lo, 3'b000} +: 8];
    v_h = word[{lo[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   v_res = {{24{sgn & v_b[7]}}, v_b};
      2'b01:   v_res = {{16{sgn & v_h[15]}}, v_h};
      default: v_res = word;
    endcase
    return v_res;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [31:0] wd,
                                          input logic [1:0] sz, input logic [1:0] lo);
    logic [31:0] v_res;
    v_res = word;
    if (sz == 2'b00) v_res[{lo, 3'b000} +: 8] = wd[7:0];
    else             v_res[{lo[1], 4'b0000} +: 16] = wd[15:0];
    return v_res;
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rdata <= 32'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_addr  <= addr;
            r_size  <= size;
            r_wr    <= wr;
            r_sign  <= sign;
            r_wdata <= wdata;
            if (w_misalign) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else if (wr && size[1]) begin
              r_state <= S_WR;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        // RD: memory word is valid combinationally this cycle
        S_RD: begin
          if (!r_wr) begin
            r_rdata <= f_extract(mem_rdata, r_size, r_addr[1:0], r_sign);
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_merge <= f_merge(mem_rdata, r_wdata, r_size, r_addr[1:0]);
            r_state <= S_WR;
          end
        end
        // WR: memory captures mem_wdata on the edge that ends this cycle
        S_WR: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rdata     = r_rdata;
  assign done      = r_done;
  assign err       = r_err;
  assign busy      = (r_state != S_IDLE);
  assign mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_we    = (r_state == S_WR) & ~rst;
  assign mem_wdata = (r_state == S_WR) ? (r_size[1] ? r_wdata : r_merge) : 32'd0;

endmodule

// File: tb/tb_sc_mem_access_unit.sv
// Bench for sc_mem_access_unit: directed table, hand sequences and random ops
// checked against a byte-array memory model.
module tb_sc_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst, req, wr, sign;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic        done, busy, err, mem_we;

  logic [31:0] dmem [64];
  logic [7:0]  ref_mem [256];
  logic [31:0] ref_rdata;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  sc_mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .sign(sign),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
    .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = dmem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;

  typedef struct {
    bit          w;
    logic [1:0]  sz;
    bit          sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          lat;
    bit          er;
    logic [31:0] mwd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int base);
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  task automatic set_word(input int base, input logic [31:0] v);
    dmem[base/4] = v;
    for (int i = 0; i < 4; i++) ref_mem[base+i] = v[8*i +: 8];
  endtask

  // Reference: memory as a byte array, loads/stores from the lane rules directly
  task automatic model_op(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output bit er,
                          output logic [31:0] mwd);
    int     n, ea, ai;
    longint v;
    bit     mis;
    logic [31:0] sh;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    ai  = int'(a[7:0]);
    ea  = (ai / n) * n;
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (ai % n) != 0;
`endif
    er  = mis;
    mwd = 32'd0;
    if (mis) begin
      lat = 1;
    end else if (!w) begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(ref_mem[ea+i]) << (8*i);
      if (sg && n < 4 && v >= (64'sd1 << (8*n-1))) v -= (64'sd1 << (8*n));
      ref_rdata = v[31:0];
      lat = 2;
    end else begin
      for (int i = 0; i < n; i++) begin
        sh = wd >> (8*i);
        ref_mem[ea+i] = sh[7:0];
      end
      mwd = word_at((ai / 4) * 4);
      lat = (n == 4) ? 2 : 3;
    end
  endtask

  task automatic run_op(input bit now, input bit w, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd, output int lat,
                        output bit we_seen, output logic [31:0] wd_seen, output bit er_seen,
                        output bit busy1);
    if (!now) @(negedge clk);
    req = 1'b1; wr = w; size = sz; sign = sg; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0;
    lat = -1; we_seen = 1'b0; wd_seen = 32'd0; er_seen = 1'b0;
    busy1 = busy;
    for (int c = 1; c <= 6; c++) begin
      if (mem_we) begin we_seen = 1'b1; wd_seen = mem_wdata; end
      if (done) begin lat = c; er_seen = err; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic apply(input string tag, input bit now, input bit w, input logic [1:0] sz,
                       input bit sg, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] e_rd, input int e_lat, input bit e_er,
                       input logic [31:0] e_mwd);
    int lat;
    bit we_s, er_s, b1;
    logic [31:0] wd_s;
    run_op(now, w, sz, sg, a, wd, lat, we_s, wd_s, er_s, b1);
    chk({tag, " latency"}, 32'(lat), 32'(e_lat));
    chk({tag, " rdata"}, rdata, e_rd);
    chk({tag, " err"}, {31'd0, er_s}, {31'd0, e_er});
    chk({tag, " busy"}, {31'd0, b1}, {31'd0, ~e_er});
    chk({tag, " mem_we"}, {31'd0, we_s}, {31'd0, w & ~e_er});
    if (w && !e_er) chk({tag, " mem_wdata"}, wd_s, e_mwd);
  endtask

  initial begin
    vec_t        tbl [15];
    int          m_lat;
    bit          m_er, any_done, we_at_rst;
    logic [31:0] m_mwd, r_wd;
    bit          r_w, r_sg;
    logic [1:0]  r_sz;
    logic [31:0] r_a;

    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sign = 1'b0; addr = 32'd0; wdata = 32'd0;
    for (int i = 0; i < 64; i++) set_word(4*i, 32'd0);
    set_word(32'h50, 32'h800000A3);
    set_word(32'h58, 32'h11223344);
    ref_rdata = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset rdata", rdata, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    @(negedge clk); rst = 1'b0;

    tbl[0]  = '{0, 2'b00, 1, 32'h50, 32'h0,        32'hFFFFFFA3, 2, 0, 32'h0};
    tbl[1]  = '{0, 2'b00, 0, 32'h50, 32'h0,        32'h000000A3, 2, 0, 32'h0};
    tbl[2]  = '{1, 2'b00, 0, 32'h52, 32'h0000005A, 32'h000000A3, 3, 0, 32'h805A00A3};
    tbl[3]  = '{0, 2'b10, 0, 32'h50, 32'h0,        32'h805A00A3, 2, 0, 32'h0};
    tbl[4]  = '{1, 2'b10, 0, 32'h54, 32'h12345678, 32'h805A00A3, 2, 0, 32'h12345678};
    tbl[5]  = '{0, 2'b01, 1, 32'h56, 32'h0,        32'h00001234, 2, 0, 32'h0};
    tbl[6]  = '{0, 2'b01, 1, 32'h54, 32'h0,        32'h00005678, 2, 0, 32'h0};
    tbl[7]  = '{0, 2'b00, 1, 32'h57, 32'h0,        32'h00000012, 2, 0, 32'h0};
    tbl[8]  = '{1, 2'b01, 0, 32'h56, 32'hFFFF8001, 32'h00000012, 3, 0, 32'h80015678};
    tbl[9]  = '{0, 2'b01, 1, 32'h56, 32'h0,        32'hFFFF8001, 2, 0, 32'h0};
    tbl[10] = '{0, 2'b01, 0, 32'h56, 32'h0,        32'h00008001, 2, 0, 32'h0};
    tbl[11] = '{0, 2'b00, 1, 32'h53, 32'h0,        32'hFFFFFF80, 2, 0, 32'h0};
`ifdef MEM_MISALIGN_TRAP_EN
    tbl[12] = '{0, 2'b10, 0, 32'h51, 32'h0,        32'hFFFFFF80, 1, 1, 32'h0};
    tbl[13] = '{0, 2'b01, 1, 32'h55, 32'h0,        32'hFFFFFF80, 1, 1, 32'h0};
`else
    tbl[12] = '{0, 2'b10, 0, 32'h51, 32'h0,        32'h805A00A3, 2, 0, 32'h0};
    tbl[13] = '{0, 2'b01, 1, 32'h55, 32'h0,        32'h00005678, 2, 0, 32'h0};
`endif
    tbl[14] = '{0, 2'b11, 0, 32'h54, 32'h0,        32'h80015678, 2, 0, 32'h0};

    for (int i = 0; i < 15; i++) begin
      model_op(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, m_lat, m_er, m_mwd);
      apply($sformatf("tbl%0d", i), 1'b0, tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd,
            tbl[i].rd, tbl[i].lat, tbl[i].er, tbl[i].mwd);
    end

    // Back-to-back: new load raised during the store's done cycle
    model_op(1, 2'b10, 0, 32'h5C, 32'hCAFEF00D, m_lat, m_er, m_mwd);
    apply("b2b store", 1'b0, 1, 2'b10, 0, 32'h5C, 32'hCAFEF00D, ref_rdata, 2, 0, 32'hCAFEF00D);
    model_op(0, 2'b10, 0, 32'h5C, 32'h0, m_lat, m_er, m_mwd);
    apply("b2b load", 1'b1, 0, 2'b10, 0, 32'h5C, 32'h0, 32'hCAFEF00D, 2, 0, 32'h0);

    // Reset asserted during the WR cycle of a halfword store
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'b01; sign = 1'b0; addr = 32'h58; wdata = 32'h0000BEEF;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1;
    we_at_rst = mem_we;
    chk("rstwr pre mem_we", {31'd0, we_at_rst}, 32'd1);
    rst = 1'b1; #1;
    chk("rstwr mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    chk("rstwr busy", {31'd0, busy}, 32'd0);
    chk("rstwr rdata", rdata, 32'd0);
    rst = 1'b0;
    ref_rdata = 32'd0;
    any_done = done;
    repeat (3) begin @(posedge clk); #1; any_done |= done; end
    chk("rstwr no done", {31'd0, any_done}, 32'd0);
    chk("rstwr mem", dmem[32'h58 / 4], 32'h11223344);

    for (int k = 0; k < 150; k++) begin
      r_w  = 1'($urandom_range(0, 1));
      r_sz = 2'($urandom_range(0, 3));
      r_sg = 1'($urandom_range(0, 1));
      r_a  = 32'($urandom_range(0, 255));
      r_wd = $urandom;
      model_op(r_w, r_sz, r_sg, r_a, r_wd, m_lat, m_er, m_mwd);
      apply($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), r_w, r_sz, r_sg, r_a, r_wd,
            ref_rdata, m_lat, m_er, m_mwd);
    end

    for (int i = 0; i < 64; i++) chk($sformatf("mem word %0d", i), dmem[i], word_at(4*i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
